// File: rtl/fu_pkg.sv
// Shared execution-unit definitions: register/ROB widths, the CDB packet
// layout and the fixed requester ids used by the completion arbiter.
package fu_pkg;

  localparam int PRF_IDX_W = 6;
  localparam int ROB_IDX_W = 5;
  localparam int DATA_W    = 64;

  localparam logic [PRF_IDX_W-1:0] ZERO_REG = '0;

  localparam int REQ_ALU  = 0;
  localparam int REQ_MULT = 1;
  localparam int REQ_LD   = 2;

  typedef struct packed {
    logic [PRF_IDX_W-1:0] tag;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [DATA_W-1:0]    value;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-requester result buffer; count is kept apart from the pointers so that
// full and empty stay distinguishable at any depth.
module cdb_req_fifo
  import fu_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush_i,
  input  logic     enq_i,
  input  cdb_pkt_t enq_pkt_i,
  input  logic     deq_i,
  output cdb_pkt_t head_pkt_o,
  output logic     nonempty_o,
  output logic     rdy_o
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  cdb_pkt_t         mem_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_enq, do_deq;

  // Ready comes from the registered count only, so a same-cycle dequeue never frees a slot early.
  assign rdy_o      = (count_q < CNT_W'(BUF_DEPTH));
  assign nonempty_o = (count_q != '0);
  assign head_pkt_o = mem_q[rd_ptr_q];
  assign do_enq     = enq_i && rdy_o && !flush_i;
  assign do_deq     = deq_i && nonempty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_enq, do_deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= enq_pkt_i;
  end

endmodule

// File: rtl/cdb_arb.sv
// Completion arbiter: buffers each execution unit's results and broadcasts one
// per cycle on the registered CDB / PRF write port in round-robin order.
module cdb_arb
  import fu_pkg::*;
#(
  parameter int NUM_REQ   = REQ_LD + 1,
  parameter int BUF_DEPTH = 2,
  parameter int PRF_IDX_W = fu_pkg::PRF_IDX_W,
  parameter int ROB_IDX_W = fu_pkg::ROB_IDX_W,
  parameter int DATA_W    = fu_pkg::DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic [NUM_REQ-1:0]             req_vld_i,
  input  logic [NUM_REQ*PRF_IDX_W-1:0]   req_tag_i,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx_i,
  input  logic [NUM_REQ*DATA_W-1:0]      req_value_i,
  output logic [NUM_REQ-1:0]             req_rdy_o,
  output logic                           cdb_vld_o,
  output logic [PRF_IDX_W-1:0]           cdb_tag_o,
  output logic [ROB_IDX_W-1:0]           cdb_rob_idx_o,
  output logic [DATA_W-1:0]              cdb_value_o,
  output logic                           ovf_err_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam cdb_pkt_t IDLE_PKT = '{tag: ZERO_REG, rob_idx: '0, value: '0};

  cdb_pkt_t           enq_pkt  [NUM_REQ];
  cdb_pkt_t           head_pkt [NUM_REQ];
  logic [NUM_REQ-1:0] nonempty, enq, deq, rdy;
  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               cdb_vld_q;
  cdb_pkt_t           cdb_pkt_q;
  logic               ovf_err_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign enq_pkt[i] = '{tag:     req_tag_i[i*PRF_IDX_W +: PRF_IDX_W],
                          rob_idx: req_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W],
                          value:   req_value_i[i*DATA_W +: DATA_W]};
    assign enq[i] = req_vld_i[i] && rdy[i] && !flush_i;
    assign deq[i] = grant_vld && (grant_idx == IDX_W'(i));

    cdb_req_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush_i),
      .enq_i      (enq[i]),
      .enq_pkt_i  (enq_pkt[i]),
      .deq_i      (deq[i]),
      .head_pkt_o (head_pkt[i]),
      .nonempty_o (nonempty[i]),
      .rdy_o      (rdy[i])
    );
  end

  // First non-empty buffer at or above rr_ptr, wrapping; no bypass from the inputs.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && nonempty[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
    rr_ptr_d = grant_vld ? IDX_W'((int'(grant_idx) + 1) % NUM_REQ) : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rr_ptr_q  <= '0;
      cdb_vld_q <= 1'b0;
      cdb_pkt_q <= IDLE_PKT;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      cdb_vld_q <= grant_vld;
      cdb_pkt_q <= grant_vld ? head_pkt[grant_idx] : IDLE_PKT;
    end
  end

  // Sticky until reset; a valid during flush is squashed, not an overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err_q <= 1'b0;
    end else if (!flush_i && |(req_vld_i & ~rdy)) begin
      ovf_err_q <= 1'b1;
    end
  end

  assign req_rdy_o     = rdy;
  assign cdb_vld_o     = cdb_vld_q;
  assign cdb_tag_o     = cdb_pkt_q.tag;
  assign cdb_rob_idx_o = cdb_pkt_q.rob_idx;
  assign cdb_value_o   = cdb_pkt_q.value;
  assign ovf_err_o     = ovf_err_q;

endmodule

// File: tb/tb_cdb_arb.sv
// Directed bench for cdb_arb: a cycle-by-cycle vector table plus hand-written
// sequences for single result, reset mid-stream and collision.
module tb_cdb_arb;

  localparam logic [63:0] VAL_BASE = 64'hC0DE_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_i;
  logic [2:0]   req_vld_i;
  logic [17:0]  req_tag_i;
  logic [14:0]  req_rob_idx_i;
  logic [191:0] req_value_i;
  logic [2:0]   req_rdy_o;
  logic         cdb_vld_o;
  logic [5:0]   cdb_tag_o;
  logic [4:0]   cdb_rob_idx_o;
  logic [63:0]  cdb_value_o;
  logic         ovf_err_o;

  int numChecks = 0;
  int numFails  = 0;

  always #5 clk = ~clk;

  cdb_arb #(
    .NUM_REQ   (3),
    .BUF_DEPTH (2),
    .PRF_IDX_W (6),
    .ROB_IDX_W (5),
    .DATA_W    (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .req_vld_i     (req_vld_i),
    .req_tag_i     (req_tag_i),
    .req_rob_idx_i (req_rob_idx_i),
    .req_value_i   (req_value_i),
    .req_rdy_o     (req_rdy_o),
    .cdb_vld_o     (cdb_vld_o),
    .cdb_tag_o     (cdb_tag_o),
    .cdb_rob_idx_o (cdb_rob_idx_o),
    .cdb_value_o   (cdb_value_o),
    .ovf_err_o     (ovf_err_o)
  );

  typedef struct {
    logic       rst;
    logic       flush;
    logic [2:0] vld;
    logic [5:0] t0, t1, t2;
    logic       evld;
    logic [5:0] etag;
    logic [2:0] erdy;
    logic       eovf;
  } vec_t;

  vec_t vecs[$];

  // Each tag carries a recognisable ROB index and value so a mixed-up entry shows.
  function automatic logic [4:0] robOf(input logic [5:0] t);
    return t[4:0] ^ 5'h15;
  endfunction

  function automatic logic [63:0] valOf(input logic [5:0] t);
    return VAL_BASE + {58'h0, t} * 64'h0000_0001_0001;
  endfunction

  function automatic vec_t mk(input logic r, input logic f, input logic [2:0] v,
                              input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2,
                              input logic evld, input logic [5:0] etag,
                              input logic [2:0] erdy, input logic eovf);
    vec_t x;
    x.rst = r; x.flush = f; x.vld = v;
    x.t0 = t0; x.t1 = t1; x.t2 = t2;
    x.evld = evld; x.etag = etag; x.erdy = erdy; x.eovf = eovf;
    return x;
  endfunction

  task automatic applyStimulus(input logic r, input logic f, input logic [2:0] v,
                               input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2);
    rst           = r;
    flush_i       = f;
    req_vld_i     = v;
    req_tag_i     = {t2, t1, t0};
    req_rob_idx_i = {robOf(t2), robOf(t1), robOf(t0)};
    req_value_i   = {valOf(t2), valOf(t1), valOf(t0)};
  endtask

  task automatic checkOutput(input string name, input logic evld, input logic [5:0] etag,
                             input logic [4:0] erob, input logic [63:0] evalue,
                             input logic [2:0] erdy, input logic eovf);
    @(negedge clk);
    numChecks++;
    if (cdb_vld_o !== evld || cdb_tag_o !== etag || cdb_rob_idx_o !== erob ||
        cdb_value_o !== evalue || req_rdy_o !== erdy || ovf_err_o !== eovf) begin
      numFails++;
      $display("[TB] FAIL %s: got vld=%0b tag=%0d rob=%0d val=%h rdy=%b ovf=%0b, want vld=%0b tag=%0d rob=%0d val=%h rdy=%b ovf=%0b",
               name, cdb_vld_o, cdb_tag_o, cdb_rob_idx_o, cdb_value_o, req_rdy_o, ovf_err_o,
               evld, etag, erob, evalue, erdy, eovf);
    end
  endtask

  task automatic checkTag(input string name, input logic evld, input logic [5:0] etag,
                          input logic [2:0] erdy, input logic eovf);
    checkOutput(name, evld, evld ? etag : 6'd0, evld ? robOf(etag) : 5'd0,
                evld ? valOf(etag) : 64'd0, erdy, eovf);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
    repeat (2) @(posedge clk);
    #1;

    //                rst flush vld     t0     t1     t2    evld etag   erdy    eovf
    // round-robin: two entries per requester, order 0,1,2,0,1,2
    vecs.push_back(mk(0, 0, 3'b111, 6'd1,  6'd2,  6'd3,  0, 6'd0,  3'b111, 0));
    vecs.push_back(mk(0, 0, 3'b111, 6'd4,  6'd5,  6'd6,  0, 6'd0,  3'b111, 0));
    vecs.push_back(mk(0, 0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd1,  3'b001, 0));
    vecs.push_back(mk(0, 0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd2,  3'b011, 0));
    vecs.push_back(mk(0, 0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd3,  3'b111, 0));
    vecs.push_back(mk(0, 0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd4,  3'b111, 0));
    vecs.push_back(mk(0, 0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd5,  3'b111, 0));
    vecs.push_back(mk(0, 0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd6,  3'b111, 0));
    // back-pressure: req1 pushes three times, third is dropped (tag 12)
    vecs.push_back(mk(0, 0, 3'b011, 6'd7,  6'd8,  6'd0,  0, 6'd0,  3'b111, 0));
    vecs.push_back(mk(0, 0, 3'b011, 6'd9,  6'd10, 6'd0,  0, 6'd0,  3'b111, 0));
    vecs.push_back(mk(0, 0, 3'b011, 6'd11, 6'd12, 6'd0,  1, 6'd7,  3'b101, 0));
    vecs.push_back(mk(0, 0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd8,  3'b110, 1));
    vecs.push_back(mk(0, 0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd9,  3'b111, 1));
    vecs.push_back(mk(0, 0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd10, 3'b111, 1));
    vecs.push_back(mk(0, 0, 3'b000, 6'd0,  6'd0,  6'd0,  1, 6'd11, 3'b111, 1));
    // flush with entries queued: broadcast in flight stays, rest discarded
    vecs.push_back(mk(0, 0, 3'b111, 6'd13, 6'd14, 6'd15, 0, 6'd0,  3'b111, 1));
    vecs.push_back(mk(0, 0, 3'b001, 6'd16, 6'd0,  6'd0,  0, 6'd0,  3'b111, 1));
    vecs.push_back(mk(0, 0, 3'b010, 6'd0,  6'd18, 6'd0,  1, 6'd14, 3'b110, 1));
    vecs.push_back(mk(0, 1, 3'b001, 6'd17, 6'd0,  6'd0,  1, 6'd15, 3'b110, 1));
    vecs.push_back(mk(0, 0, 3'b000, 6'd0,  6'd0,  6'd0,  0, 6'd0,  3'b111, 1));
    // reset clears ovf; then a flush while req1 is full must not set it
    vecs.push_back(mk(1, 0, 3'b000, 6'd0,  6'd0,  6'd0,  0, 6'd0,  3'b111, 1));
    vecs.push_back(mk(0, 0, 3'b011, 6'd19, 6'd20, 6'd0,  0, 6'd0,  3'b111, 0));
    vecs.push_back(mk(0, 0, 3'b011, 6'd21, 6'd22, 6'd0,  0, 6'd0,  3'b111, 0));
    vecs.push_back(mk(0, 1, 3'b010, 6'd0,  6'd23, 6'd0,  1, 6'd19, 3'b101, 0));
    vecs.push_back(mk(0, 0, 3'b000, 6'd0,  6'd0,  6'd0,  0, 6'd0,  3'b111, 0));
    vecs.push_back(mk(0, 0, 3'b000, 6'd0,  6'd0,  6'd0,  0, 6'd0,  3'b111, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].vld, vecs[i].t0, vecs[i].t1, vecs[i].t2);
      checkTag($sformatf("row%0d", i), vecs[i].evld, vecs[i].etag, vecs[i].erdy, vecs[i].eovf);
      nextCycle();
    end

    // single result with explicit payload, visible two cycles later for one cycle
    applyStimulus(1'b0, 1'b0, 3'b001, 6'd12, 6'd0, 6'd0);
    req_rob_idx_i[4:0] = 5'd3;
    req_value_i[63:0]  = 64'hDEAD;
    checkOutput("single_t0", 1'b0, 6'd0, 5'd0, 64'd0, 3'b111, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
    checkOutput("single_t1", 1'b0, 6'd0, 5'd0, 64'd0, 3'b111, 1'b0);
    nextCycle();
    checkOutput("single_t2", 1'b1, 6'd12, 5'd3, 64'hDEAD, 3'b111, 1'b0);
    nextCycle();
    checkOutput("single_t3", 1'b0, 6'd0, 5'd0, 64'd0, 3'b111, 1'b0);
    nextCycle();

    // reset with three entries queued: nothing from them ever appears
    applyStimulus(1'b0, 1'b0, 3'b111, 6'd30, 6'd31, 6'd32);
    checkTag("rstmid_fill", 1'b0, 6'd0, 3'b111, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
    checkTag("rstmid_assert", 1'b0, 6'd0, 3'b111, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
    checkTag("rstmid_after", 1'b0, 6'd0, 3'b111, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b100, 6'd0, 6'd0, 6'd40);
    checkTag("rstmid_req2_t0", 1'b0, 6'd0, 3'b111, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
    checkTag("rstmid_req2_t1", 1'b0, 6'd0, 3'b111, 1'b0);
    nextCycle();
    checkTag("rstmid_req2_t2", 1'b1, 6'd40, 3'b111, 1'b0);
    nextCycle();
    checkTag("rstmid_no_stale", 1'b0, 6'd0, 3'b111, 1'b0);
    nextCycle();

    // collision with rr_ptr back at 0: req0 first, then req1
    applyStimulus(1'b0, 1'b0, 3'b011, 6'd4, 6'd9, 6'd0);
    checkTag("coll_t0", 1'b0, 6'd0, 3'b111, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
    checkTag("coll_t1", 1'b0, 6'd0, 3'b111, 1'b0);
    nextCycle();
    checkTag("coll_t2", 1'b1, 6'd4, 3'b111, 1'b0);
    nextCycle();
    checkTag("coll_t3", 1'b1, 6'd9, 3'b111, 1'b0);
    nextCycle();
    checkTag("coll_t4", 1'b0, 6'd0, 3'b111, 1'b0);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
